// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the multi-channel tick scheduler.
// Period value 0 stands for a full 2**CNT_W cycle period.
package tick_sched_pkg;

  localparam int CNT_W_DEF = 13;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  localparam logic  RST_ARMED = 1'b1;
  localparam logic  RST_TICK  = 1'b0;
  localparam mode_e RST_MODE  = MODE_PERIODIC;

  function automatic logic [31:0] period_decode(
    input logic [31:0] p,
    input int unsigned w
  );
    return (p == 32'd0) ? (32'd1 << w) : p;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick channel: down-counter, period, mode and armed flag.
// A load rewrites the channel; reload_period feeds the next expiry reload.
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int DEFAULT_PERIOD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] load_period,
  input  mode_e            load_mode,
  input  logic [CNT_W-1:0] reload_period,
  output logic [CNT_W-1:0] period,
  output logic             expire,
  output logic             tick,
  output logic             armed
);

  logic [CNT_W-1:0] cnt;
  mode_e            mode;
  logic             active;

  always_comb begin
    active = armed & run;
    expire = active & (cnt == '0);
  end

  // A load still lets a coincident expiry tick out, but the
  // counter restarts from the newly written period.
  always_ff @(posedge clk) begin
    if (reset) begin
      period <= CNT_W'(DEFAULT_PERIOD);
      cnt    <= '0;
      mode   <= RST_MODE;
      armed  <= RST_ARMED;
      tick   <= RST_TICK;
    end else begin
      tick <= expire;
      if (load) begin
        period <= load_period;
        mode   <= load_mode;
        cnt    <= load_period - CNT_W'(1);
        armed  <= 1'b1;
      end else if (expire) begin
        period <= reload_period;
        cnt    <= reload_period - CNT_W'(1);
        if (mode == MODE_ONESHOT)
          armed <= 1'b0;
      end else if (active) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel tick generator with config decode.
// Optional ch0 difficulty ramp under `TICK_SCHED_SPEEDUP_EN.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int DEFAULT_PERIOD = 0,
`ifdef TICK_SCHED_SPEEDUP_EN
  parameter int RAMP_EVERY     = 8,
  parameter int RAMP_STEP      = 64,
  parameter int RAMP_MIN       = 1024,
`endif
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_oneshot,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  armed
);

  logic             wr;
  logic [N_CH-1:0]  load;
  logic [N_CH-1:0]  expire;
  logic [CNT_W-1:0] per [N_CH];
  logic [CNT_W-1:0] reload0;
  mode_e            wr_mode;
  logic             unused_expire;

  assign cfg_ready     = ~reset;
  assign wr            = cfg_valid & cfg_ready;
  assign wr_mode       = cfg_oneshot ? MODE_ONESHOT
                                     : MODE_PERIODIC;
  assign unused_expire = ^expire;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign load[i] = wr & (cfg_ch == CH_W'(i));

    tick_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .run           (ch_en[i] & ~pause),
      .load          (load[i]),
      .load_period   (cfg_period),
      .load_mode     (wr_mode),
      .reload_period ((i == 0) ? reload0 : per[i]),
      .period        (per[i]),
      .expire        (expire[i]),
      .tick          (tick[i]),
      .armed         (armed[i])
    );
  end

`ifdef TICK_SCHED_SPEEDUP_EN
  localparam int RW = $clog2(RAMP_EVERY + 1);

  logic [RW-1:0]    rcnt;
  logic             ramp_hit;
  logic [CNT_W:0]   eff;
  logic [CNT_W-1:0] ramp_period;

  always_comb begin
    eff = (CNT_W+1)'(period_decode(32'(per[0]), CNT_W));
    ramp_hit = (rcnt == RW'(RAMP_EVERY - 1));
    if (eff <= (CNT_W+1)'(RAMP_MIN + RAMP_STEP))
      ramp_period = CNT_W'(RAMP_MIN);
    else
      ramp_period = CNT_W'(eff - (CNT_W+1)'(RAMP_STEP));
    reload0 = ramp_hit ? ramp_period : per[0];
  end

  always_ff @(posedge clk) begin
    if (reset || load[0])
      rcnt <= '0;
    else if (expire[0])
      rcnt <= ramp_hit ? '0 : rcnt + RW'(1);
  end
`else
  assign reload0 = per[0];
`endif

endmodule
